// File: rtl/fmult_pkg.sv
// Shared constants, state encoding and helpers for the G.726 FMULT datapath.
// Optional pipeline stage in fmult_core is enabled by defining FMULT_PIPE_EN.
package fmult_pkg;

  localparam int AN_W   = 16;  // AnBn coefficient, two's complement
  localparam int SR_W   = 11;  // SRnDQn float: sign, 4-bit exp, 6-bit mant
  localparam int WMAG_W = 15;

  localparam int SR_SIGN    = 10;
  localparam int SR_EXP_HI  = 9;
  localparam int SR_EXP_LO  = 6;
  localparam int SR_MANT_HI = 5;
  localparam int SR_MANT_LO = 0;

  localparam logic [11:0] WMANT_RND   = 12'd48;
  localparam logic [4:0]  SHIFT_PIVOT = 5'd26;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] bit_length13(input logic [12:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 13; i++) begin
      if (v[i]) n = 4'(i + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/fmult_core.sv
// G.726 FMULT: signed product of an AnBn coefficient and an SRnDQn float operand.
// Defining FMULT_PIPE_EN registers WMANT/WEXP/sign ahead of the shifter (latency 1).
module fmult_core
  import fmult_pkg::*;
(
`ifdef FMULT_PIPE_EN
  input  logic            clk,
  input  logic            reset,
`endif
  input  logic [AN_W-1:0] an,
  input  logic [SR_W-1:0] sr,
  output logic [AN_W-1:0] product
);

  logic [AN_W-1:0]   an_abs;
  logic [12:0]       an_mag;
  logic [3:0]        an_exp;
  logic [5:0]        an_mant;
  logic [11:0]       mant_prod;
  logic [7:0]        wmant;
  logic [4:0]        wexp;
  logic              sign;
  logic [7:0]        sh_wmant;
  logic [4:0]        sh_wexp;
  logic              sh_sign;
  logic [WMAG_W-1:0] wmag;

  // -32768 has no positive twin; its magnitude folds to 0 after the 13-bit mask.
  assign an_abs    = an[AN_W-1] ? (AN_W'(0) - an) : an;
  assign an_mag    = 13'(an_abs >> 2);
  assign an_exp    = bit_length13(an_mag);
  assign an_mant   = (an_mag == 13'd0) ? 6'd32 : 6'({an_mag, 6'b0} >> an_exp);
  assign mant_prod = {6'b0, an_mant} * {6'b0, sr[SR_MANT_HI:SR_MANT_LO]};
  assign wmant     = 8'((mant_prod + WMANT_RND) >> 4);
  assign wexp      = {1'b0, an_exp} + {1'b0, sr[SR_EXP_HI:SR_EXP_LO]};
  assign sign      = an[AN_W-1] ^ sr[SR_SIGN];

`ifdef FMULT_PIPE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_wmant <= '0;
      sh_wexp  <= '0;
      sh_sign  <= 1'b0;
    end else begin
      sh_wmant <= wmant;
      sh_wexp  <= wexp;
      sh_sign  <= sign;
    end
  end
`else
  assign sh_wmant = wmant;
  assign sh_wexp  = wexp;
  assign sh_sign  = sign;
`endif

  always_comb begin
    if (sh_wexp <= SHIFT_PIVOT) begin
      wmag = WMAG_W'({5'b0, sh_wmant, 7'b0} >> (SHIFT_PIVOT - sh_wexp));
    end else begin
      wmag = WMAG_W'({5'b0, sh_wmant, 7'b0} << (sh_wexp - SHIFT_PIVOT));
    end
  end

  assign product = sh_sign ? (AN_W'(0) - {1'b0, wmag}) : {1'b0, wmag};

endmodule

// File: rtl/fmult_accum_seq.sv
// Time-multiplexed G.726 predictor: one FMULT walks all zero then pole taps, producing SEZ/SE.
// FMULT_PIPE_EN adds one pipeline stage inside fmult_core; DRAIN then lasts two cycles.
module fmult_accum_seq
  import fmult_pkg::*;
#(
  parameter int NUM_ZEROS = 6,
  parameter int NUM_POLES = 2,
  parameter int CH_W      = 5,
  parameter int TI_W      = $clog2(NUM_ZEROS + NUM_POLES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_in0,
  input  logic            scan_in1,
  input  logic            scan_in2,
  input  logic            scan_in3,
  input  logic            scan_in4,
  input  logic            scan_enable,
  input  logic            test_mode,
  output logic            scan_out0,
  output logic            scan_out1,
  output logic            scan_out2,
  output logic            scan_out3,
  output logic            scan_out4,
  input  logic            start,
  input  logic [CH_W-1:0] start_ch,
  output logic            busy,
  output logic            tap_rd,
  output logic [TI_W-1:0] tap_idx,
  input  logic [15:0]     tap_coef,
  input  logic [10:0]     tap_op,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output logic [14:0]     sez,
  output logic [14:0]     se,
  output state_t          fsm_state
);

  // Handshake: start is a request honoured only in IDLE (no ready; busy flags the job).
  // tap_rd/tap_idx is a read with fixed one-cycle latency; out_valid is a one-cycle strobe.

  localparam int T = NUM_ZEROS + NUM_POLES;
  localparam logic [TI_W-1:0] LAST_TAP  = TI_W'(T - 1);
  localparam logic [TI_W-1:0] LAST_ZERO = TI_W'(NUM_ZEROS - 1);

  state_t            state;
  logic [CH_W-1:0]   job_ch;
  logic              drain_done;
  logic              data_vld;
  logic [TI_W-1:0]   data_idx;
  logic              acc_vld;
  logic [TI_W-1:0]   acc_idx;
  logic [15:0]       product;
  logic [15:0]       acc;
  logic [15:0]       acc_next;
  logic [14:0]       sezi_half;

  assign scan_out0 = test_mode & scan_enable & scan_in0;
  assign scan_out1 = test_mode & scan_enable & scan_in1;
  assign scan_out2 = test_mode & scan_enable & scan_in2;
  assign scan_out3 = test_mode & scan_enable & scan_in3;
  assign scan_out4 = test_mode & scan_enable & scan_in4;
  assign fsm_state = state;

  fmult_core u_fmult (
`ifdef FMULT_PIPE_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .an      (tap_coef),
    .sr      (tap_op),
    .product (product)
  );

`ifdef FMULT_PIPE_EN
  logic            drain_wait;
  logic            pipe_vld;
  logic [TI_W-1:0] pipe_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= 1'b0;
      pipe_idx <= '0;
    end else begin
      pipe_vld <= data_vld;
      pipe_idx <= data_idx;
    end
  end

  assign acc_vld    = pipe_vld;
  assign acc_idx    = pipe_idx;
  assign drain_done = !drain_wait;
`else
  assign acc_vld    = data_vld;
  assign acc_idx    = data_idx;
  assign drain_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      tap_rd    <= 1'b0;
      tap_idx   <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      job_ch    <= '0;
`ifdef FMULT_PIPE_EN
      drain_wait <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            busy    <= 1'b1;
            tap_rd  <= 1'b1;
            tap_idx <= '0;
            job_ch  <= start_ch;
          end
        end
        S_FETCH: begin
          if (tap_idx == LAST_TAP) begin
            tap_rd  <= 1'b0;
            tap_idx <= '0;
            state   <= S_DRAIN;
`ifdef FMULT_PIPE_EN
            drain_wait <= 1'b1;
`endif
          end else begin
            tap_idx <= tap_idx + TI_W'(1);
          end
        end
        S_DRAIN: begin
`ifdef FMULT_PIPE_EN
          drain_wait <= 1'b0;
`endif
          if (drain_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_ch    <= job_ch;
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign acc_next = acc + product;

  // The final tap lands on the same edge that enters DONE, so sez/se are ready with out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_vld  <= 1'b0;
      data_idx  <= '0;
      acc       <= '0;
      sezi_half <= '0;
      sez       <= '0;
      se        <= '0;
    end else begin
      data_vld <= tap_rd;
      data_idx <= tap_idx;
      if (state == S_IDLE && start) begin
        acc <= '0;
      end else if (acc_vld) begin
        acc <= acc_next;
        if (acc_idx == LAST_ZERO) sezi_half <= acc_next[15:1];
        if (acc_idx == LAST_TAP) begin
          sez <= sezi_half;
          se  <= acc_next[15:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fmult_accum_seq.sv
// Self-checking bench for fmult_accum_seq: directed table, random jobs, handshake, mid-job reset,
// and a second small-parameter instance. Honours FMULT_PIPE_EN for expected latencies.
`timescale 1ns/1ps
module tb_fmult_accum_seq;
  import fmult_pkg::*;

  localparam int NZ = 6, NP = 2, T = NZ + NP, CW = 5;
  localparam int NZ2 = 3, NP2 = 1, T2 = NZ2 + NP2, CW2 = 2;
`ifdef FMULT_PIPE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT  = T + 2 + EXTRA;
  localparam int LAT2 = T2 + 2 + EXTRA;
  localparam int JOB  = T + 3 + EXTRA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  initial forever #5 clk = ~clk;

  logic [4:0] scan_in = '0;
  logic scan_enable = 1'b0, test_mode = 1'b0;
  logic [4:0] scan_out_a, scan_out_b;

  logic start, start2;
  logic [CW-1:0] start_ch, out_ch;
  logic [CW2-1:0] start_ch2, out_ch2;
  logic busy, busy2, tap_rd, tap_rd2, out_valid, out_valid2;
  logic [2:0] tap_idx;
  logic [1:0] tap_idx2;
  logic [15:0] tap_coef, tap_coef2;
  logic [10:0] tap_op, tap_op2;
  logic [14:0] sez, se, sez2, se2;
  state_t fsm_state, fsm_state2;

  logic [7:0][15:0] mem_coef, mem2_coef;
  logic [7:0][10:0] mem_op, mem2_op;

  fmult_accum_seq #(.NUM_ZEROS(NZ), .NUM_POLES(NP), .CH_W(CW)) dut (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in[0]), .scan_in1(scan_in[1]), .scan_in2(scan_in[2]),
    .scan_in3(scan_in[3]), .scan_in4(scan_in[4]),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out_a[0]), .scan_out1(scan_out_a[1]), .scan_out2(scan_out_a[2]),
    .scan_out3(scan_out_a[3]), .scan_out4(scan_out_a[4]),
    .start(start), .start_ch(start_ch), .busy(busy), .tap_rd(tap_rd), .tap_idx(tap_idx),
    .tap_coef(tap_coef), .tap_op(tap_op), .out_valid(out_valid), .out_ch(out_ch),
    .sez(sez), .se(se), .fsm_state(fsm_state)
  );

  fmult_accum_seq #(.NUM_ZEROS(NZ2), .NUM_POLES(NP2), .CH_W(CW2)) dut2 (
    .clk(clk), .reset(reset),
    .scan_in0(scan_in[0]), .scan_in1(scan_in[1]), .scan_in2(scan_in[2]),
    .scan_in3(scan_in[3]), .scan_in4(scan_in[4]),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out_b[0]), .scan_out1(scan_out_b[1]), .scan_out2(scan_out_b[2]),
    .scan_out3(scan_out_b[3]), .scan_out4(scan_out_b[4]),
    .start(start2), .start_ch(start_ch2), .busy(busy2), .tap_rd(tap_rd2), .tap_idx(tap_idx2),
    .tap_coef(tap_coef2), .tap_op(tap_op2), .out_valid(out_valid2), .out_ch(out_ch2),
    .sez(sez2), .se(se2), .fsm_state(fsm_state2)
  );

  // ---------------- tap RAM responders (garbage when not reading) ----------------
  always begin : resp1
    logic r;
    int i;
    @(negedge clk);
    r = tap_rd;
    i = int'(tap_idx);
    @(posedge clk);
    #1;
    if (r) begin tap_coef = mem_coef[i]; tap_op = mem_op[i]; end
    else begin tap_coef = 16'($urandom); tap_op = 11'($urandom); end
  end

  always begin : resp2
    logic r;
    int i;
    @(negedge clk);
    r = tap_rd2;
    i = int'(tap_idx2);
    @(posedge clk);
    #1;
    if (r) begin tap_coef2 = mem2_coef[i]; tap_op2 = mem2_op[i]; end
    else begin tap_coef2 = 16'($urandom); tap_op2 = 11'($urandom); end
  end

  // ---------------- reference model ----------------
  function automatic int fmult_ref(input logic [15:0] an, input logic [10:0] sr);
    int a, mag, e, mant, wexp, wmant, wmag;
    a = an[15] ? int'(an) - 65536 : int'(an);
    mag = ((a < 0) ? -a : a) >> 2;
    mag = mag & 8191;
    e = 0;
    while (e < 13 && (mag >> e) != 0) e++;
    mant = (mag == 0) ? 32 : ((mag << 6) >> e);
    wexp = e + int'(sr[9:6]);
    wmant = (mant * int'(sr[5:0]) + 48) >> 4;
    wmag = (wexp <= 26) ? ((wmant << 7) >> (26 - wexp)) : ((wmant << 7) << (wexp - 26));
    wmag = wmag & 32767;
    if (an[15] ^ sr[10]) return (65536 - wmag) & 65535;
    return wmag;
  endfunction

  function automatic logic [29:0] est_ref(input int nz, input int nt,
                                          input logic [7:0][15:0] c, input logic [7:0][10:0] o);
    int zs, ts, p;
    zs = 0;
    ts = 0;
    for (int i = 0; i < nt; i++) begin
      p = fmult_ref(c[i], o[i]);
      ts = (ts + p) & 65535;
      if (i < nz) zs = (zs + p) & 65535;
    end
    return {15'((zs >> 1) & 32767), 15'((ts >> 1) & 32767)};
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0, errors = 0;
  logic [CW+29:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", 32'(out_valid), 32'd0);
      end else begin
        logic [CW+29:0] e;
        e = exp_q.pop_front();
        check("out_ch", 32'(out_ch), 32'(e[CW+29:30]));
        check("sez", 32'(sez), 32'(e[29:15]));
        check("se", 32'(se), 32'(e[14:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_job(input logic [CW-1:0] ch, input logic [29:0] est);
    bit seen;
    exp_q.push_back({ch, est});
    @(posedge clk); #1 start = 1'b1; start_ch = ch;
    @(posedge clk); #1 start = 1'b0; start_ch = CW'($urandom);
    seen = 1'b0;
    for (int n = 1; n <= LAT + 4 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (out_valid) begin
        seen = 1'b1;
        check("latency", 32'(n), 32'(LAT));
      end
    end
    check("out_valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_job2(input logic [CW2-1:0] ch);
    logic [29:0] est;
    bit seen;
    est = est_ref(NZ2, T2, mem2_coef, mem2_op);
    @(posedge clk); #1 start2 = 1'b1; start_ch2 = ch;
    @(posedge clk); #1 start2 = 1'b0; start_ch2 = CW2'($urandom);
    seen = 1'b0;
    for (int n = 1; n <= LAT2 + 4 && !seen; n++) begin
      @(negedge clk);
      if (out_valid2) begin
        seen = 1'b1;
        check("latency2", 32'(n), 32'(LAT2));
        check("out_ch2", 32'(out_ch2), 32'(ch));
        check("sez2", 32'(sez2), 32'(est[29:15]));
        check("se2", 32'(se2), 32'(est[14:0]));
      end
    end
    check("out_valid2_seen", 32'(seen), 32'd1);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < T; i++) begin
      mem_coef[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      mem_op[i]   = 11'($urandom);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic [7:0][15:0] coef;
    logic [7:0][10:0] op;
    logic [CW-1:0]    ch;
    logic [14:0]      sez;
    logic [14:0]      se;
  } vec_t;
  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int k, nrd, nov, last;
    start = 1'b0; start_ch = '0; start2 = 1'b0; start_ch2 = '0;
    mem_coef = '0; mem_op = '0; mem2_coef = '0; mem2_op = '0;
    tap_coef = '0; tap_op = '0; tap_coef2 = '0; tap_op2 = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tap_rd", 32'(tap_rd), 32'd0);
    check("rst_tap_idx", 32'(tap_idx), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_sez", 32'(sez), 32'd0);
    check("rst_se", 32'(se), 32'd0);

    vecs[0] = '{coef: {8{16'h4000}}, op: {8{11'h2A0}}, ch: 5'h03, sez: 15'h0C90, se: 15'h10C0};
    vecs[1] = '{coef: 128'h0, op: {8{11'h2A0}}, ch: 5'h11, sez: 15'h7DE8, se: 15'h7DE8};
    vecs[1].coef[0] = 16'hC000;
    vecs[2] = vecs[1];
    vecs[2].op[0] = 11'h6A0;
    vecs[2].ch = 5'h1F; vecs[2].sez = 15'h0218; vecs[2].se = 15'h0218;
    vecs[3] = '{coef: {8{16'h7FFC}}, op: {8{11'h3FF}}, ch: 5'h0A, sez: 15'h6200, se: 15'h5800};
    vecs[4] = '{coef: 128'h0, op: {8{11'h2A0}}, ch: 5'h15, sez: 15'h0000, se: 15'h7DE8};
    vecs[4].coef[T-1] = 16'hC000;
    vecs[5] = '{coef: 128'h0, op: {8{11'h2A0}}, ch: 5'h06, sez: 15'h0218, se: 15'h0218};
    vecs[5].coef[NZ-1] = 16'h4000;

    for (int v = 0; v < 6; v++) begin
      mem_coef = vecs[v].coef;
      mem_op   = vecs[v].op;
      run_job(vecs[v].ch, {vecs[v].sez, vecs[v].se});
    end

    for (int j = 0; j < 16; j++) begin
      randomize_mem();
      run_job(CW'($urandom), est_ref(NZ, T, mem_coef, mem_op));
    end

    // start held high: one acceptance per JOB cycles, contiguous tap_idx runs
    randomize_mem();
    for (int j = 0; j < 3; j++) exp_q.push_back({5'h09, est_ref(NZ, T, mem_coef, mem_op)});
    @(posedge clk); #1 start = 1'b1; start_ch = 5'h09;
    k = 0; nrd = 0; nov = 0; last = -1;
    for (int c = 0; c < 3 * JOB + 4; c++) begin
      @(posedge clk); #1;
      if (c == 2 * JOB) start = 1'b0;
      @(negedge clk);
      if (tap_rd) begin
        check("hs_tap_idx", 32'(tap_idx), 32'(k));
        k = (k + 1) % T;
        nrd++;
      end
      if (out_valid) begin
        nov++;
        if (last < 0) check("hs_first_latency", 32'(c + 1), 32'(LAT));
        else check("hs_spacing", 32'(c + 1 - last), 32'(JOB));
        last = c + 1;
      end
    end
    check("hs_rd_count", 32'(nrd), 32'(3 * T));
    check("hs_job_count", 32'(nov), 32'd3);

    // reset sampled at the end of cycle 4 aborts the job silently
    randomize_mem();
    @(posedge clk); #1 start = 1'b1; start_ch = 5'h1C;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tap_rd", 32'(tap_rd), 32'd0);
    check("abort_tap_idx", 32'(tap_idx), 32'd0);
    check("abort_out_ch", 32'(out_ch), 32'd0);
    check("abort_sez", 32'(sez), 32'd0);
    check("abort_se", 32'(se), 32'd0);
    repeat (LAT + 4) @(negedge clk);
    randomize_mem();
    run_job(5'h12, est_ref(NZ, T, mem_coef, mem_op));

    // small instance: homing vector, isolated taps, random
    for (int i = 0; i < T2; i++) begin mem2_coef[i] = 16'h0000; mem2_op[i] = 11'h020; end
    run_job2(2'd1);
    for (int t = 0; t < T2; t++) begin
      for (int i = 0; i < T2; i++) begin
        mem2_coef[i] = (i == t) ? 16'($urandom_range(1, 65535)) : 16'h0000;
        mem2_op[i]   = 11'($urandom);
      end
      run_job2(CW2'(t));
    end
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < T2; i++) begin
        mem2_coef[i] = 16'($urandom);
        mem2_op[i]   = 11'($urandom);
      end
      run_job2(CW2'($urandom));
    end

    repeat (2) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
